read_check_pattern: RTL and testbench
=====================================

Name: read_check_pattern

Overview:
- Reader/checker counterpart to the RAM pattern writer.
- After a start request it sweeps RAM addresses 0..PATTERN_COUNT-1 with read enables and compares each returned word against the writer's pattern (data = address).
- Reports pass/fail, a saturating mismatch count and the first failing address.
- Sits on the RAM read port of the devkit memory-test harness, downstream of the writer's end_out.

Parameters:
- ADDR_WIDTH, 14: RAM address width.
- DATA_WIDTH, 32: RAM data width.
- PATTERN_COUNT, 100: number of words read and checked. Legal range 1..2**ADDR_WIDTH.
- RE_POLARITY, 1'b1: active level of re.
- READ_LATENCY, 1: cycles from re/addr presented to rdata valid. Legal range 1..4.

Ports:
- clk, input, 1: single clock, all logic on posedge.
- reset_n, input, 1: asynchronous active-low reset.
- start_in, input, 1: run request. Asynchronous level, internally double-synchronised.
- re, output, 1: RAM read enable, polarity set by RE_POLARITY.
- addr, output, ADDR_WIDTH: RAM read address, registered.
- rdata, input, DATA_WIDTH: RAM read data.
- start_out, output, 1: high from first read issued until the next start edge or abort.
- end_out, output, 1: high after the last compare completes; held until the next start edge.
- fail, output, 1: sticky mismatch flag for the current run.
- error_count, output, ADDR_WIDTH+1: mismatches in the current run, saturating at all ones.
- first_err_addr, output, ADDR_WIDTH: address of the first mismatch; 0 if none.

Behaviour:
- Reset (reset_n low, asynchronous):
  - re = ~RE_POLARITY.
  - addr, error_count, first_err_addr = 0.
  - start_out, end_out, fail = 0.
  - Synchroniser and pipeline are cleared. State = IDLE.
- Start detect: s1 <= start_in, s2 <= s1. A start edge is s1 & ~s2.
  - Edge in IDLE or DONE: clear fail, error_count, first_err_addr, end_out and start_out; go to READ.
- READ:
  - re = RE_POLARITY and addr = read counter, both registered.
  - Counter runs 0..PATTERN_COUNT-1, one address per cycle, no gaps.
  - First re is seen after the 3rd rising edge following start_in going high (2 synchroniser stages plus output register).
  - start_out rises with the first re.
  - After addr PATTERN_COUNT-1 is issued: re deasserts the next cycle; go to DRAIN.
- Compare pipeline:
  - A valid bit and an address tag shift alongside each read, depth READ_LATENCY.
  - When the tag emerges, rdata is compared against the expected word: the tag zero-extended or truncated to DATA_WIDTH.
  - Results are registered: fail, error_count and first_err_addr update 1 cycle after rdata is sampled.
  - first_err_addr latches only on the first mismatch of the run.
  - error_count saturates at 2**(ADDR_WIDTH+1)-1 and never wraps.
- DRAIN: wait until the pipeline is empty and the final compare is registered. Then end_out = 1 and go to DONE.
- DONE: all outputs hold. re stays inactive. A new start edge restarts the run.
- Abort (s1 low while in READ or DRAIN):
  - Go to IDLE. re inactive next cycle. Pipeline valid bits cleared, so in-flight reads are discarded.
  - start_out drops. end_out stays 0.
  - fail, error_count and first_err_addr keep their partial values.
- Simultaneous events:
  - reset_n dominates everything.
  - Abort takes priority over a DRAIN->DONE transition in the same cycle.
  - A start edge cannot coincide with an abort, because s1 is high on an edge.
- PATTERN_COUNT = 2**ADDR_WIDTH: the read counter reaches all ones, then stops; it never wraps to 0 within a run.
- PATTERN_COUNT = 1: exactly one read, then DRAIN.
- Latency from first re to end_out = PATTERN_COUNT + READ_LATENCY + 1 cycles.

Test Plan:
- Clean run, defaults, model RAM preloaded with data[a]=a:
  - 100 consecutive re pulses, addr 0..99.
  - fail=0, error_count=0.
  - end_out rises 102 cycles after the first re and holds.
- Single fault (word 37 = 0xFFFFFFFF), READ_LATENCY=3:
  - fail=1, error_count=1, first_err_addr=37.
  - end_out rises 104 cycles after the first re.
- All words corrupted, ADDR_WIDTH=4, PATTERN_COUNT=16:
  - addr 0..15 with no wrap.
  - error_count=16, first_err_addr=0.
- Abort: drop start_in after addr 50 is issued:
  - re inactive within 3 cycles of start_in falling; end_out stays 0.
  - Re-raise start_in: counters clear and the sweep restarts at addr 0.
- RE_POLARITY=0 and reset_n pulsed low mid-READ:
  - Immediately: re=1 (inactive), all status outputs 0, no further reads until a new start edge.
- Back-to-back runs (lower then raise start_in after DONE, first run with 1 error):
  - On the new start edge, fail, error_count and end_out clear; second clean run reports 0 errors.

Source files
------------

// File: rtl/read_check_pattern_if.sv
// RAM read-port bundle between the pattern checker and the memory.
//   re    : read enable (active level chosen by the checker's RE_POLARITY)
//   addr  : read address, registered in the checker
//   rdata : read data returned by the RAM, READ_LATENCY cycles after re/addr
// master = checker side, slave = RAM side.
interface read_check_pattern_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  re;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output re, output addr, input rdata);
    modport slave  (input re, input addr, output rdata);
endinterface

// File: rtl/read_check_pattern.sv
// RAM pattern checker: on a start edge, sweeps addresses 0..PATTERN_COUNT-1
// and compares each returned word with its own address (the writer's pattern).
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   start_in         : asynchronous run request (level), double-synchronised
//   ram              : RAM read port (re / addr out, rdata in)
//   start_out        : high from the first read of a run until restart/abort
//   end_out          : high once the last compare is registered, until restart
//   fail             : sticky mismatch flag for the current run
//   error_count      : saturating mismatch count
//   first_err_addr   : address of the first mismatch of the run (0 if none)
module read_check_pattern #(
    parameter int   ADDR_WIDTH    = 14,
    parameter int   DATA_WIDTH    = 32,
    parameter int   PATTERN_COUNT = 100,
    parameter logic RE_POLARITY   = 1'b1,
    parameter int   READ_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_in,
    read_check_pattern_if.master    ram,
    output logic                    start_out,
    output logic                    end_out,
    output logic                    fail,
    output logic [ADDR_WIDTH:0]     error_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t state, next_state;

    logic s1, s2;
    logic start_edge;
    logic run_clear;   // start edge accepted: clear status, begin a sweep
    logic issue;       // present a read this cycle
    logic abort;       // start request dropped while busy
    logic finish;      // drain complete, raise end_out
    logic pipe_empty;

    logic [ADDR_WIDTH-1:0] rd_cnt;

    // Stage 0 is the registered re/addr seen by the RAM; stage READ_LATENCY
    // lines up with valid rdata.
    logic [READ_LATENCY:0]                 vld_pipe;
    logic [READ_LATENCY:0][ADDR_WIDTH-1:0] tag_pipe;

    logic [DATA_WIDTH-1:0] exp_word;
    logic                  mismatch;

    assign start_edge = s1 & ~s2;
    assign pipe_empty = ~|vld_pipe;
    assign exp_word   = DATA_WIDTH'(tag_pipe[READ_LATENCY]);
    assign mismatch   = vld_pipe[READ_LATENCY] && (ram.rdata != exp_word);

    assign ram.re   = vld_pipe[0] ? RE_POLARITY : ~RE_POLARITY;
    assign ram.addr = tag_pipe[0];

    // ---------------------------------------------------------------- sync
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= start_in;
            s2 <= s1;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: if (start_edge) next_state = READ;
            READ: begin
                if (!s1)                       next_state = IDLE;
                else if (rd_cnt == LAST_ADDR)  next_state = DRAIN;
            end
            DRAIN: begin
                // abort wins over completion in the same cycle
                if (!s1)            next_state = IDLE;
                else if (pipe_empty) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        run_clear = 1'b0;
        issue     = 1'b0;
        abort     = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE, DONE: run_clear = start_edge;
            READ: begin
                issue = s1;
                abort = ~s1;
            end
            DRAIN: begin
                abort  = ~s1;
                finish = s1 & pipe_empty;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt         <= '0;
            vld_pipe       <= '0;
            tag_pipe       <= '0;
            start_out      <= 1'b0;
            end_out        <= 1'b0;
            fail           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
        end else begin
            // read issue stage
            vld_pipe[0] <= issue;
            if (issue) tag_pipe[0] <= rd_cnt;

            // abort flushes in-flight reads so they are never compared
            for (int i = 1; i <= READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~abort;
                tag_pipe[i] <= tag_pipe[i-1];
            end

            // counter stops at the last address so a full-range sweep never wraps
            if (run_clear)
                rd_cnt <= '0;
            else if (issue && rd_cnt != LAST_ADDR)
                rd_cnt <= rd_cnt + 1'b1;

            if (run_clear || abort) start_out <= 1'b0;
            else if (issue)         start_out <= 1'b1;

            if (run_clear)   end_out <= 1'b0;
            else if (finish) end_out <= 1'b1;

            if (run_clear) begin
                fail           <= 1'b0;
                error_count    <= '0;
                first_err_addr <= '0;
            end else if (mismatch && !abort) begin
                fail <= 1'b1;
                if (!fail) first_err_addr <= tag_pipe[READ_LATENCY];
                if (error_count != '1) error_count <= error_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_read_check_pattern.sv
module tb_read_check_pattern;
    localparam int AW0 = 14;
    localparam int AW1 = 4;
    localparam int DW  = 32;

    typedef struct {
        logic fail;
        int   ec;
        int   fea;
        int   lat;
        int   nrd;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic start0  = 1'b0;
    logic start1  = 1'b0;

    read_check_pattern_if #(.ADDR_WIDTH(AW0), .DATA_WIDTH(DW)) bus0 ();
    read_check_pattern_if #(.ADDR_WIDTH(AW1), .DATA_WIDTH(DW)) bus1 ();

    logic           so0, eo0, f0, so1, eo1, f1;
    logic [AW0:0]   ec0;
    logic [AW0-1:0] fea0;
    logic [AW1:0]   ec1;
    logic [AW1-1:0] fea1;

    // defaults: 100 words, latency 1, active-high re
    read_check_pattern #(.ADDR_WIDTH(AW0), .DATA_WIDTH(DW), .PATTERN_COUNT(100),
                         .RE_POLARITY(1'b1), .READ_LATENCY(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .start_in(start0), .ram(bus0),
        .start_out(so0), .end_out(eo0), .fail(f0),
        .error_count(ec0), .first_err_addr(fea0));

    // full address range, latency 3, active-low re
    read_check_pattern #(.ADDR_WIDTH(AW1), .DATA_WIDTH(DW), .PATTERN_COUNT(16),
                         .RE_POLARITY(1'b0), .READ_LATENCY(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .start_in(start1), .ram(bus1),
        .start_out(so1), .end_out(eo1), .fail(f1),
        .error_count(ec1), .first_err_addr(fea1));

    // RAM models
    logic [DW-1:0] mem0 [128];
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] p1a, p1b;

    always @(posedge clk) if (bus0.re === 1'b1) bus0.rdata <= mem0[bus0.addr[6:0]];

    always @(posedge clk) begin
        p1a        <= mem1[bus1.addr];
        p1b        <= p1a;
        bus1.rdata <= p1b;
    end

    // scoreboard state
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [AW0-1:0] ea0_q[$];
    logic [AW1-1:0] ea1_q[$];
    res_t res0_q[$];
    res_t res1_q[$];
    res_t r;
    logic [AW0-1:0] e0;
    logic [AW1-1:0] e1;
    int nrd0 = 0, nrd1 = 0, fre0 = 0, fre1 = 0, endc0 = 0, endc1 = 0, stc0 = 0, stc1 = 0;
    bit ends0 = 1'b0, ends1 = 1'b0;
    logic eo0_p = 1'b0, eo1_p = 1'b0, st0_p = 1'b0, st1_p = 1'b0;

    // Read-address monitor: every read the DUT issues is popped against the
    // expected sweep order.
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (bus0.re === 1'b1) begin
                if (nrd0 == 0) fre0 = cyc;
                nrd0++;
                checks++;
                if (ea0_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr0 unexpected read got=%0d exp=none", bus0.addr);
                end else begin
                    e0 = ea0_q.pop_front();
                    if (bus0.addr !== e0) begin
                        errors++;
                        $display("FAIL rd_addr0 got=%0d exp=%0d", bus0.addr, e0);
                    end
                end
            end
            if (bus1.re === 1'b0) begin
                if (nrd1 == 0) fre1 = cyc;
                nrd1++;
                checks++;
                if (ea1_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr1 unexpected read got=%0d exp=none", bus1.addr);
                end else begin
                    e1 = ea1_q.pop_front();
                    if (bus1.addr !== e1) begin
                        errors++;
                        $display("FAIL rd_addr1 got=%0d exp=%0d", bus1.addr, e1);
                    end
                end
            end
            if (eo0 && !eo0_p) begin ends0 = 1'b1; endc0 = cyc; end
            if (eo1 && !eo1_p) begin ends1 = 1'b1; endc1 = cyc; end
            if (start0 && !st0_p) stc0 = cyc;
            if (start1 && !st1_p) stc1 = cyc;
        end
        eo0_p = eo0; eo1_p = eo1; st0_p = start0; st1_p = start1;
    end

    task automatic wait_end0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            if (ends0) ok = 1'b1;
        end
        #1;
    endtask

    task automatic wait_end1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            if (ends1) ok = 1'b1;
        end
        #1;
    endtask

    task automatic launch0(input int nwords, input res_t exp);
        ea0_q.delete();
        for (int a = 0; a < nwords; a++) ea0_q.push_back(AW0'(a));
        res0_q.push_back(exp);
        @(posedge clk); #1;
        nrd0 = 0; ends0 = 1'b0; start0 = 1'b1;
    endtask

    task automatic launch1(input res_t exp);
        ea1_q.delete();
        for (int a = 0; a < 16; a++) ea1_q.push_back(AW1'(a));
        res1_q.push_back(exp);
        @(posedge clk); #1;
        nrd1 = 0; ends1 = 1'b0; start1 = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.re !== 1'b0) begin errors++; $display("FAIL reset_re0 got=%b exp=0", bus0.re); end
        checks++; if (bus1.re !== 1'b1) begin errors++; $display("FAIL reset_re1 got=%b exp=1", bus1.re); end
        checks++; if ({bus0.addr, so0, eo0, f0, ec0, fea0} !== '0) begin errors++;
            $display("FAIL reset_status0 got=%0h exp=0", {bus0.addr, so0, eo0, f0, ec0, fea0}); end
        checks++; if ({bus1.addr, so1, eo1, f1, ec1, fea1} !== '0) begin errors++;
            $display("FAIL reset_status1 got=%0h exp=0", {bus1.addr, so1, eo1, f1, ec1, fea1}); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_clean();
        bit ok;
        for (int a = 0; a < 128; a++) mem0[a] = DW'(a);
        launch0(100, '{fail: 1'b0, ec: 0, fea: 0, lat: 102, nrd: 100});
        wait_end0(ok);
        r = res0_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL clean_timeout got=no_end exp=end_out"); end
        checks++; if (f0 !== r.fail) begin errors++; $display("FAIL clean_fail got=%b exp=%b", f0, r.fail); end
        checks++; if (int'(ec0) != r.ec) begin errors++; $display("FAIL clean_ec got=%0d exp=%0d", ec0, r.ec); end
        checks++; if (endc0 - fre0 != r.lat) begin errors++; $display("FAIL clean_latency got=%0d exp=%0d", endc0 - fre0, r.lat); end
        checks++; if (nrd0 != r.nrd) begin errors++; $display("FAIL clean_reads got=%0d exp=%0d", nrd0, r.nrd); end
        checks++; if (fre0 - stc0 != 3) begin errors++; $display("FAIL first_re_delay got=%0d exp=3", fre0 - stc0); end
        checks++; if (so0 !== 1'b1) begin errors++; $display("FAIL clean_start_out got=%b exp=1", so0); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({eo0, bus0.re} !== 2'b10) begin errors++; $display("FAIL done_hold got=%b exp=10", {eo0, bus0.re}); end
        checks++; if (bus0.addr !== AW0'(99)) begin errors++; $display("FAIL done_addr got=%0d exp=99", bus0.addr); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        mem0[37] = '1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        launch0(100, '{fail: 1'b1, ec: 1, fea: 37, lat: 102, nrd: 100});
        wait_end0(ok);
        r = res0_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL b2b1_timeout got=no_end exp=end_out"); end
        checks++; if ({f0, int'(ec0), int'(fea0)} !== {r.fail, r.ec, r.fea}) begin errors++;
            $display("FAIL b2b1_status got=%b/%0d/%0d exp=%b/%0d/%0d", f0, ec0, fea0, r.fail, r.ec, r.fea); end
        mem0[37] = DW'(37);
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        launch0(100, '{fail: 1'b0, ec: 0, fea: 0, lat: 102, nrd: 100});
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({f0, ec0, eo0} !== '0) begin errors++; $display("FAIL b2b_clear got=%0h exp=0", {f0, ec0, eo0}); end
        wait_end0(ok);
        r = res0_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL b2b2_timeout got=no_end exp=end_out"); end
        checks++; if ({f0, int'(ec0), int'(fea0)} !== {r.fail, r.ec, r.fea}) begin errors++;
            $display("FAIL b2b2_status got=%b/%0d/%0d exp=%b/%0d/%0d", f0, ec0, fea0, r.fail, r.ec, r.fea); end
        checks++; if (endc0 - fre0 != r.lat) begin errors++; $display("FAIL b2b2_latency got=%0d exp=%0d", endc0 - fre0, r.lat); end
    endtask

    task automatic test_abort();
        bit ok;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        launch0(100, '{fail: 1'b0, ec: 0, fea: 0, lat: 102, nrd: 100});
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            if (nrd0 >= 51) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL abort_wait got=%0d exp=51", nrd0); end
        #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus0.re, so0, eo0} !== 3'b000) begin errors++; $display("FAIL abort_idle got=%b exp=000", {bus0.re, so0, eo0}); end
        checks++; if (nrd0 > 53) begin errors++; $display("FAIL abort_reads got=%0d exp=<=53", nrd0); end
        res0_q.delete();
        ea0_q.delete();
        repeat (10) @(posedge clk);
        #1;
        checks++; if ({ends0, eo0} !== 2'b00) begin errors++; $display("FAIL abort_no_end got=%b exp=00", {ends0, eo0}); end
        launch0(100, '{fail: 1'b0, ec: 0, fea: 0, lat: 102, nrd: 100});
        wait_end0(ok);
        r = res0_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got=no_end exp=end_out"); end
        checks++; if ({f0, int'(ec0), nrd0} !== {r.fail, r.ec, r.nrd}) begin errors++;
            $display("FAIL restart_status got=%b/%0d/%0d exp=%b/%0d/%0d", f0, ec0, nrd0, r.fail, r.ec, r.nrd); end
    endtask

    task automatic test_single_fault();
        bit ok;
        for (int a = 0; a < 16; a++) mem1[a] = DW'(a);
        mem1[7] = '1;
        launch1('{fail: 1'b1, ec: 1, fea: 7, lat: 20, nrd: 16});
        wait_end1(ok);
        r = res1_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL fault_timeout got=no_end exp=end_out"); end
        checks++; if ({f1, int'(ec1), int'(fea1)} !== {r.fail, r.ec, r.fea}) begin errors++;
            $display("FAIL fault_status got=%b/%0d/%0d exp=%b/%0d/%0d", f1, ec1, fea1, r.fail, r.ec, r.fea); end
        checks++; if (endc1 - fre1 != r.lat) begin errors++; $display("FAIL fault_latency got=%0d exp=%0d", endc1 - fre1, r.lat); end
        checks++; if (nrd1 != r.nrd) begin errors++; $display("FAIL fault_reads got=%0d exp=%0d", nrd1, r.nrd); end
    endtask

    task automatic test_all_bad();
        bit ok;
        for (int a = 0; a < 16; a++) mem1[a] = ~DW'(a);
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        launch1('{fail: 1'b1, ec: 16, fea: 0, lat: 20, nrd: 16});
        wait_end1(ok);
        r = res1_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL allbad_timeout got=no_end exp=end_out"); end
        checks++; if ({f1, int'(ec1), int'(fea1)} !== {r.fail, r.ec, r.fea}) begin errors++;
            $display("FAIL allbad_status got=%b/%0d/%0d exp=%b/%0d/%0d", f1, ec1, fea1, r.fail, r.ec, r.fea); end
        checks++; if (nrd1 != r.nrd) begin errors++; $display("FAIL allbad_reads got=%0d exp=%0d", nrd1, r.nrd); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if ({bus1.re, bus1.addr} !== {1'b1, 4'hF}) begin errors++;
            $display("FAIL allbad_nowrap got=%b/%0d exp=1/15", bus1.re, bus1.addr); end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        launch1('{fail: 1'b1, ec: 16, fea: 0, lat: 20, nrd: 16});
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            if (nrd1 >= 10) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL midrd_wait got=%0d exp=10", nrd1); end
        #1;
        checks++; if (ec1 == '0) begin errors++; $display("FAIL midrd_pre_errors got=%0d exp=>0", ec1); end
        reset_n = 1'b0;
        start1  = 1'b0;
        start0  = 1'b0;
        #1;
        checks++; if (bus1.re !== 1'b1) begin errors++; $display("FAIL midrd_re got=%b exp=1", bus1.re); end
        checks++; if ({bus1.addr, so1, eo1, f1, ec1, fea1} !== '0) begin errors++;
            $display("FAIL midrd_status got=%0h exp=0", {bus1.addr, so1, eo1, f1, ec1, fea1}); end
        checks++; if ({eo0, f0, ec0} !== '0) begin errors++; $display("FAIL midrd_dut0 got=%0h exp=0", {eo0, f0, ec0}); end
        res1_q.delete();
        ea1_q.delete();
        nrd1 = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if ({nrd1, bus1.re, eo1} !== {32'd0, 1'b1, 1'b0}) begin errors++;
            $display("FAIL midrd_quiet got=%0d/%b/%b exp=0/1/0", nrd1, bus1.re, eo1); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_back_to_back();
        test_abort();
        test_single_fault();
        test_all_bad();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
